// File: rtl/pulse_cross_clk_pkg.sv
// Shared constants for the pulse clock-crossing block.
// The synchronizer depth is the only tunable; it is kept inside the range
// where metastability settling is adequate and the round trip stays short.
package pulse_cross_clk_pkg;

    localparam int SYNC_STAGES_MIN     = 2;
    localparam int SYNC_STAGES_MAX     = 4;
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Force a requested synchronizer depth into the legal range so a bad
    // override can never build a one-flop (unsafe) or zero-width chain.
    function automatic int clamp_sync_stages(input int requested);
        int result;
        result = requested;
        if (requested < SYNC_STAGES_MIN) begin
            result = SYNC_STAGES_MIN;
        end else if (requested > SYNC_STAGES_MAX) begin
            result = SYNC_STAGES_MAX;
        end
        return result;
    endfunction

endpackage

// File: rtl/pulse_cross_clk_sync_bit.sv
// Multi-flop single-bit synchronizer with synchronous active-high reset.
// Only level signals that change at most once per handshake phase pass
// through here, so a single-bit chain is sufficient.
module pulse_cross_clk_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_ff;

    // Shift the asynchronous level through the chain; first flop may go metastable.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/pulse_cross_clk.sv
// Single-cycle strobe transfer between two unrelated clock domains.
// A four-phase req/ack handshake carries each accepted source strobe across:
//   src: req rises on accept, falls once the echoed ack (ack_s) is seen.
//   dst: a rising edge of the synchronized req produces one out_pulse; the
//        registered req level (req_seen) is echoed back as the ack.
// A new strobe is accepted only when req and ack_s are both low, i.e. the
// previous handshake has fully returned to idle. Strobes arriving while busy
// is high are dropped, not queued.
module pulse_cross_clk
    import pulse_cross_clk_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic src_clk,
    input  logic dst_clk,
    input  logic rst,
    input  logic in_pulse,
    output logic out_pulse,
    output logic busy
);

    localparam int STAGES = clamp_sync_stages(SYNC_STAGES);

    // ------------------------------------------------------------------
    // Source domain
    // ------------------------------------------------------------------
    logic req;
    logic ack_s;
    logic accept;

    // Accept a strobe only when the previous handshake has fully unwound.
    assign accept = in_pulse & ~req & ~ack_s & ~rst;

    // busy covers the accept cycle itself so callers see it immediately.
    assign busy = accept | req | ack_s;

    // Raise req on accept, drop it once the destination has echoed it back.
    always_ff @(posedge src_clk) begin
        if (rst) begin
            req <= 1'b0;
        end else if (accept) begin
            req <= 1'b1;
        end else if (req && ack_s) begin
            req <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Destination domain
    // ------------------------------------------------------------------
    logic req_s;
    logic req_seen;

    // Bring the req level into the destination clock domain.
    pulse_cross_clk_sync_bit #(
        .STAGES (STAGES)
    ) u_req_sync (
        .clk (dst_clk),
        .rst (rst),
        .d   (req),
        .q   (req_s)
    );

    // Remember the last synchronized req level and strobe on its rising edge.
    always_ff @(posedge dst_clk) begin
        if (rst) begin
            req_seen  <= 1'b0;
            out_pulse <= 1'b0;
        end else begin
            req_seen  <= req_s;
            out_pulse <= req_s & ~req_seen;
        end
    end

    // ------------------------------------------------------------------
    // Acknowledge path back to the source domain
    // ------------------------------------------------------------------
    // Echo req_seen back so the source knows the destination has observed req.
    pulse_cross_clk_sync_bit #(
        .STAGES (STAGES)
    ) u_ack_sync (
        .clk (src_clk),
        .rst (rst),
        .d   (req_seen),
        .q   (ack_s)
    );

endmodule

// File: tb/tb_pulse_cross_clk.sv
// Bench for pulse_cross_clk: one task per scenario, a scoreboard queue holding
// the destination cycle count at each accepted strobe, and a destination-side
// monitor that pops it when out_pulse fires and checks latency and width.
module tb_pulse_cross_clk;

    localparam int SYNC_STAGES = 2;

    logic src_clk  = 1'b0;
    logic dst_clk  = 1'b0;
    logic rst      = 1'b1;
    logic in_pulse = 1'b0;
    logic out_pulse;
    logic busy;

    int src_half = 50;
    int dst_half = 33;

    int checks       = 0;
    int errors       = 0;
    int dst_cyc      = 0;
    int out_count    = 0;
    bit hold_mode    = 1'b0;
    int hold_count   = 0;
    int last_out_cyc = -1000;
    logic out_prev   = 1'b0;

    logic [31:0] exp_q[$];

    pulse_cross_clk #(
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .src_clk   (src_clk),
        .dst_clk   (dst_clk),
        .rst       (rst),
        .in_pulse  (in_pulse),
        .out_pulse (out_pulse),
        .busy      (busy)
    );

    // Clock and reset block
    always #(src_half) src_clk = ~src_clk;
    always #(dst_half) dst_clk = ~dst_clk;

    always @(posedge dst_clk) dst_cyc = dst_cyc + 1;

    // Destination monitor / scoreboard
    always @(negedge dst_clk) begin
        logic [31:0] t0;
        int lat;
        if (out_pulse === 1'b1) begin
            out_count = out_count + 1;
            checks = checks + 1;
            if (out_prev === 1'b1) begin
                errors = errors + 1;
                $display("FAIL out_pulse_width: out_pulse high on consecutive dst cycles (cyc %0d), required one cycle", dst_cyc);
            end
            if (hold_mode) begin
                hold_count = hold_count + 1;
                if (hold_count > 1) begin
                    checks = checks + 1;
                    if (dst_cyc - last_out_cyc < 4) begin
                        errors = errors + 1;
                        $display("FAIL held_separation: out_pulses %0d dst cycles apart, required >= 4", dst_cyc - last_out_cyc);
                    end
                end
                last_out_cyc = dst_cyc;
            end else if (out_prev !== 1'b1) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_out_pulse: out_pulse at dst cyc %0d, required no pulse", dst_cyc);
                end else begin
                    t0 = exp_q.pop_front();
                    lat = dst_cyc - int'(t0);
                    if (lat < SYNC_STAGES || lat > SYNC_STAGES + 2) begin
                        errors = errors + 1;
                        $display("FAIL latency: %0d dst edges, required %0d..%0d", lat, SYNC_STAGES, SYNC_STAGES + 2);
                    end
                end
            end
        end
        out_prev = out_pulse;
    end

    // Driver tasks
    task automatic send_pulse();
        @(posedge src_clk);
        #1 in_pulse = 1'b1;
        @(posedge src_clk);
        exp_q.push_back(32'(dst_cyc));
        #1 in_pulse = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            @(negedge src_clk);
            n++;
        end
        checks = checks + 1;
        if (busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL %s_idle_timeout: busy=%b after %0d src cycles, required 0", name, busy, max_cycles);
        end
        repeat (4) @(negedge dst_clk);
    endtask

    task automatic set_clocks(input int s_half, input int d_half);
        src_half = s_half;
        dst_half = d_half;
        repeat (2) @(posedge src_clk);
        repeat (2) @(posedge dst_clk);
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge src_clk);
        #1 in_pulse = 1'b1;
        repeat (3) @(posedge src_clk);
        @(negedge src_clk);
        checks = checks + 2;
        if (busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_busy: busy=%b during reset with in_pulse=1, required 0", busy);
        end
        if (out_pulse !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_out_pulse: out_pulse=%b during reset, required 0", out_pulse);
        end
        in_pulse = 1'b0;
        @(posedge src_clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge dst_clk);
        checks = checks + 2;
        if (busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL post_reset_busy: busy=%b, required 0", busy);
        end
        if (out_count != 0) begin
            errors = errors + 1;
            $display("FAIL post_reset_pulses: %0d out_pulses, required 0", out_count);
        end
    endtask

    task automatic test_single();
        int c0;
        int busy_cyc;
        c0 = out_count;
        @(posedge src_clk);
        #1 in_pulse = 1'b1;
        @(negedge src_clk);
        checks = checks + 1;
        if (busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL single_busy_accept: busy=%b in accept cycle, required 1", busy);
        end
        @(posedge src_clk);
        exp_q.push_back(32'(dst_cyc));
        #1 in_pulse = 1'b0;
        busy_cyc = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge src_clk);
            if (busy !== 1'b1) break;
            busy_cyc++;
        end
        checks = checks + 2;
        if (busy_cyc > 14 || busy_cyc < 2 * SYNC_STAGES + 2) begin
            errors = errors + 1;
            $display("FAIL single_busy_span: busy high %0d src cycles, required %0d..14", busy_cyc, 2 * SYNC_STAGES + 2);
        end
        if (busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL single_busy_release: busy=%b, required 0", busy);
        end
        repeat (6) @(negedge dst_clk);
        checks = checks + 2;
        if (out_count - c0 != 1) begin
            errors = errors + 1;
            $display("FAIL single_count: %0d out_pulses, required 1", out_count - c0);
        end
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL single_pending: %0d expected pulses missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_burst(input string name, input int s_half, input int d_half);
        int c0;
        set_clocks(s_half, d_half);
        c0 = out_count;
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge src_clk);
            send_pulse();
            wait_idle(name, 400);
        end
        repeat (4) @(negedge dst_clk);
        checks = checks + 2;
        if (out_count - c0 != 5) begin
            errors = errors + 1;
            $display("FAIL %s_count: %0d out_pulses, required 5", name, out_count - c0);
        end
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s_pending: %0d expected pulses missing, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_pulse_while_busy();
        int c0;
        set_clocks(50, 33);
        c0 = out_count;
        send_pulse();
        @(posedge src_clk);
        #1;
        checks = checks + 1;
        if (busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL busy_t1: busy=%b one cycle after accept, required 1", busy);
        end
        in_pulse = 1'b1;
        @(posedge src_clk);
        #1 in_pulse = 1'b0;
        checks = checks + 1;
        if (busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL busy_t2: busy=%b after dropped pulse, required 1", busy);
        end
        wait_idle("while_busy", 100);
        repeat (6) @(negedge dst_clk);
        checks = checks + 2;
        if (out_count - c0 != 1) begin
            errors = errors + 1;
            $display("FAIL while_busy_count: %0d out_pulses, required 1", out_count - c0);
        end
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL while_busy_pending: %0d expected pulses missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_transfer();
        int c0;
        set_clocks(50, 33);
        c0 = out_count;
        @(posedge src_clk);
        #1 in_pulse = 1'b1;
        @(posedge src_clk);
        #1 in_pulse = 1'b0;
        rst = 1'b1;
        repeat (4) @(posedge src_clk);
        #1 rst = 1'b0;
        checks = checks + 1;
        if (busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL mid_reset_busy: busy=%b after reset, required 0", busy);
        end
        repeat (20) @(negedge dst_clk);
        checks = checks + 1;
        if (out_count - c0 != 0) begin
            errors = errors + 1;
            $display("FAIL mid_reset_ghost: %0d out_pulses after reset, required 0", out_count - c0);
        end
        send_pulse();
        wait_idle("after_reset", 100);
        repeat (6) @(negedge dst_clk);
        checks = checks + 2;
        if (out_count - c0 != 1) begin
            errors = errors + 1;
            $display("FAIL after_reset_count: %0d out_pulses, required 1", out_count - c0);
        end
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL after_reset_pending: %0d expected pulses missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_held_high();
        set_clocks(50, 33);
        hold_count = 0;
        last_out_cyc = -1000;
        hold_mode = 1'b1;
        @(posedge src_clk);
        #1 in_pulse = 1'b1;
        repeat (10) @(posedge src_clk);
        #1 in_pulse = 1'b0;
        wait_idle("held", 100);
        repeat (6) @(negedge dst_clk);
        hold_mode = 1'b0;
        checks = checks + 1;
        if (hold_count < 1 || hold_count > 2) begin
            errors = errors + 1;
            $display("FAIL held_count: %0d out_pulses for 10-cycle hold, required 1..2", hold_count);
        end
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // Sequencer and final report
    initial begin
        test_reset();
        test_single();
        test_burst("fast_to_slow", 25, 200);
        test_burst("slow_to_fast", 200, 25);
        test_pulse_while_busy();
        test_reset_mid_transfer();
        test_held_high();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
